// File: rtl/seg7_capture_if.sv
// -----------------------------------------------------------------------------
// seg7_capture_if
// Bundles the multiplexed 7-segment display bus seen by the capture block
// together with the decoded results it produces.
//   ce_i      : sample/settle-count enable
//   seg_i     : active-low segment bus, {a,b,c,d,e,f,g,dp}
//   an_i      : active-low anode bus, one zero selects the digit being shown
//   bcd_o     : committed digit codes, digit i in bcd_o[4i+3:4i]
//   dp_o      : committed decimal point per digit, 1 = lit
//   valid_o   : digit has committed at least once since reset
//   err_o     : sticky flag, an unrecognised segment pattern was sampled
//   update_o  : one-cycle pulse when any committed value changes
// master drives the display bus, slave is the capture block.
// -----------------------------------------------------------------------------
interface seg7_capture_if #(
  parameter int DIGITS = 4
);
  logic                  ce_i;
  logic [7:0]            seg_i;
  logic [DIGITS-1:0]     an_i;
  logic [4*DIGITS-1:0]   bcd_o;
  logic [DIGITS-1:0]     dp_o;
  logic [DIGITS-1:0]     valid_o;
  logic                  err_o;
  logic                  update_o;

  modport master (
    output ce_i, seg_i, an_i,
    input  bcd_o, dp_o, valid_o, err_o, update_o
  );

  modport slave (
    input  ce_i, seg_i, an_i,
    output bcd_o, dp_o, valid_o, err_o, update_o
  );
endinterface

// File: rtl/seg7_capture.sv
// -----------------------------------------------------------------------------
// seg7_capture
// Watches a multiplexed active-low segment/anode bus and rebuilds the per-digit
// BCD values being displayed. Each digit is sampled once per anode dwell after
// a settle time, and a value is only committed once it has been seen
// identically on STABLE_SCANS consecutive scans.
//   clk_i : clock, all logic on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : seg7_capture_if slave (ce/seg/an in, bcd/dp/valid/err/update out)
// -----------------------------------------------------------------------------
module seg7_capture #(
  parameter int DIGITS       = 4,
  parameter int SETTLE       = 4,
  parameter int STABLE_SCANS = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  seg7_capture_if.slave  bus
);

  localparam int         IDXW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [8:0] SETTLE_C   = 9'(SETTLE);
  localparam logic [8:0] SETTLE_MAX = 9'(SETTLE + 1);
  localparam logic [3:0] STABLE_C   = 4'(STABLE_SCANS);

  // Segment pattern (a..g, active-low) to digit code; blank is F, anything
  // unrecognised is E.
  function automatic logic [3:0] seg_decode(input logic [6:0] pat);
    case (pat)
      7'b0000001: seg_decode = 4'd0;
      7'b1001111: seg_decode = 4'd1;
      7'b0010010: seg_decode = 4'd2;
      7'b0000110: seg_decode = 4'd3;
      7'b1001100: seg_decode = 4'd4;
      7'b0100100: seg_decode = 4'd5;
      7'b0100000: seg_decode = 4'd6;
      7'b0001111: seg_decode = 4'd7;
      7'b0000000: seg_decode = 4'd8;
      7'b0000100: seg_decode = 4'd9;
      7'b1111111: seg_decode = 4'hF;
      default:    seg_decode = 4'hE;
    endcase
  endfunction

  logic [DIGITS-1:0]   an_q;
  logic [8:0]          settle_q;
  logic [8:0]          settle_d;
  logic [4:0]          cand_q  [DIGITS];
  logic [3:0]          match_q [DIGITS];
  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   valid_q;
  logic                err_q;
  logic                update_q;

  logic [7:0]          zero_cnt_s;
  logic [IDXW-1:0]     idx_s;
  logic                an_valid_s;
  logic                an_stable_s;
  logic                sample_s;
  logic [3:0]          code_s;
  logic                dp_s;
  logic [4:0]          samp_val_s;
  logic [3:0]          match_d;
  logic                commit_s;
  logic                changed_s;

  // Anode qualification: count active-low bits and locate the selected digit.
  always_comb begin
    zero_cnt_s = 8'd0;
    idx_s      = {IDXW{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      if (!bus.an_i[i]) begin
        zero_cnt_s = zero_cnt_s + 8'd1;
        idx_s      = IDXW'(i);
      end else begin
        zero_cnt_s = zero_cnt_s;
      end
    end
    an_valid_s = (zero_cnt_s == 8'd1);
  end

  // Settle counter next state and the single sample point per dwell; the
  // counter parks at SETTLE+1 so the sample condition cannot recur.
  always_comb begin
    an_stable_s = (bus.an_i == an_q);
    sample_s    = bus.ce_i && an_valid_s && an_stable_s && (settle_q == SETTLE_C);
    if (!an_stable_s || !an_valid_s) begin
      settle_d = 9'd0;
    end else if (bus.ce_i && (settle_q != SETTLE_MAX)) begin
      settle_d = settle_q + 9'd1;
    end else begin
      settle_d = settle_q;
    end
  end

  // Decode the sample and run the per-digit stability rule for the selected digit.
  always_comb begin
    code_s     = seg_decode(bus.seg_i[7:1]);
    dp_s       = ~bus.seg_i[0];
    samp_val_s = {code_s, dp_s};
    if (samp_val_s == cand_q[idx_s]) begin
      if (match_q[idx_s] >= STABLE_C) begin
        match_d = STABLE_C;
      end else begin
        match_d = match_q[idx_s] + 4'd1;
      end
    end else begin
      match_d = 4'd1;
    end
    commit_s  = sample_s && (match_d == STABLE_C);
    // A first commit always counts as a change so VALID rising is announced.
    changed_s = !valid_q[idx_s] ||
                ({bcd_q[{idx_s, 2'b00} +: 4], dp_q[idx_s]} != samp_val_s);
  end

  // State and registered outputs; reset overrides any sample on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_q     <= {DIGITS{1'b1}};
      settle_q <= 9'd0;
      for (int i = 0; i < DIGITS; i++) begin
        cand_q[i]  <= 5'b11110;
        match_q[i] <= 4'd0;
      end
      bcd_q    <= {(4*DIGITS){1'b1}};
      dp_q     <= {DIGITS{1'b0}};
      valid_q  <= {DIGITS{1'b0}};
      err_q    <= 1'b0;
      update_q <= 1'b0;
    end else begin
      an_q     <= bus.an_i;
      settle_q <= settle_d;
      update_q <= 1'b0;
      if (sample_s) begin
        cand_q[idx_s]  <= samp_val_s;
        match_q[idx_s] <= match_d;
        if (code_s == 4'hE) begin
          err_q <= 1'b1;
        end
        if (commit_s) begin
          bcd_q[{idx_s, 2'b00} +: 4] <= code_s;
          dp_q[idx_s]                <= dp_s;
          valid_q[idx_s]             <= 1'b1;
          update_q                   <= changed_s;
        end
      end
    end
  end

  assign bus.bcd_o    = bcd_q;
  assign bus.dp_o     = dp_q;
  assign bus.valid_o  = valid_q;
  assign bus.err_o    = err_q;
  assign bus.update_o = update_q;

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

  localparam int DIGITS = 4;
  localparam int SETTLE = 4;
  localparam int STABLE = 2;
  localparam logic [6:0] PAT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0000100};

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_capture_if #(.DIGITS(DIGITS)) bus ();

  seg7_capture #(.DIGITS(DIGITS), .SETTLE(SETTLE), .STABLE_SCANS(STABLE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_upd = 0;
  int base_upd;
  int last_upd_c;

  logic [3:0]        m_bcd   [DIGITS];
  logic              m_dp    [DIGITS];
  logic              m_valid [DIGITS];
  logic [4:0]        m_cand  [DIGITS];
  int                m_cnt   [DIGITS];
  logic              m_err;
  logic [DIGITS-1:0] prev_an;

  function automatic logic [7:0] segv(int v, logic dp);
    return {PAT[v], ~dp};
  endfunction

  function automatic logic [3:0] decode_ref(logic [6:0] p);
    for (int k = 0; k < 10; k++) if (p == PAT[k]) return 4'(k);
    if (p == 7'h7F) return 4'hF;
    return 4'hE;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < DIGITS; d++) begin
      m_bcd[d] = 4'hF; m_dp[d] = 1'b0; m_valid[d] = 1'b0;
      m_cand[d] = 5'b11110; m_cnt[d] = 0;
    end
    m_err = 1'b0;
  endfunction

  // One accepted sample of digit d; returns whether UPDATE must pulse.
  function automatic logic model_sample(int d, logic [6:0] p, logic dp);
    logic [3:0] code;
    logic [4:0] v;
    logic       upd;
    code = decode_ref(p);
    v    = {code, dp};
    upd  = 1'b0;
    if (code == 4'hE) m_err = 1'b1;
    if (v == m_cand[d]) m_cnt[d] = (m_cnt[d] + 1 > STABLE) ? STABLE : m_cnt[d] + 1;
    else begin m_cand[d] = v; m_cnt[d] = 1; end
    if (m_cnt[d] == STABLE) begin
      upd = !m_valid[d] || ({m_bcd[d], m_dp[d]} != v);
      m_bcd[d] = code; m_dp[d] = dp; m_valid[d] = 1'b1;
    end
    return upd;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(logic exp_upd);
    logic [4*DIGITS-1:0] eb;
    logic [DIGITS-1:0]   ed, ev;
    for (int d = 0; d < DIGITS; d++) begin
      eb[4*d +: 4] = m_bcd[d]; ed[d] = m_dp[d]; ev[d] = m_valid[d];
    end
    check("bcd",    32'(bus.bcd_o),    32'(eb));
    check("dp",     32'(bus.dp_o),     32'(ed));
    check("valid",  32'(bus.valid_o),  32'(ev));
    check("err",    32'(bus.err_o),    32'(m_err));
    check("update", 32'(bus.update_o), 32'(exp_upd));
    if (bus.update_o === 1'b1) n_upd++;
  endtask

  // Hold one anode/segment pattern for len cycles, CE low for gap_len cycles from gap_at.
  task automatic dwell(logic [DIGITS-1:0] an, logic [7:0] seg, int len, int gap_at, int gap_len);
    int   ce_cnt, zeros, d;
    logic ce, upd;
    ce_cnt = 0; zeros = 0; d = 0;
    for (int k = 0; k < DIGITS; k++) if (!an[k]) begin zeros++; d = k; end
    bus.an_i  = an;
    bus.seg_i = seg;
    for (int c = 0; c < len; c++) begin
      ce = !(c >= gap_at && c < gap_at + gap_len);
      bus.ce_i = ce;
      @(posedge clk); #1;
      upd = 1'b0;
      // Edge 0 registers the anode change; the SETTLE+1-th enabled edge after it samples.
      if (c >= 1 && ce) begin
        ce_cnt++;
        if (ce_cnt == SETTLE + 1 && zeros == 1) upd = model_sample(d, seg[7:1], ~seg[0]);
      end
      check_outputs(upd);
      if (bus.update_o === 1'b1) last_upd_c = c;
    end
    prev_an = an;
  endtask

  task automatic scan(logic [7:0] s3, logic [7:0] s2, logic [7:0] s1, logic [7:0] s0);
    dwell(4'b0111, s3, 16, 0, 0);
    dwell(4'b1011, s2, 16, 0, 0);
    dwell(4'b1101, s1, 16, 0, 0);
    dwell(4'b1110, s0, 16, 0, 0);
  endtask

  initial begin
    logic [7:0]        s_bad;
    logic [DIGITS-1:0] an;
    logic [3:0]        tgt    [DIGITS];
    logic              tgt_dp [DIGITS];
    logic [6:0]        p;
    int                d, r;

    bus.ce_i = 1'b0; bus.an_i = 4'hF; bus.seg_i = 8'hFF; prev_an = 4'hF;
    model_reset();

    // reset
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; check_outputs(1'b0); end
    check("rst_bcd", 32'(bus.bcd_o), 32'h0000FFFF);
    rst = 1'b0;

    // steady scan 3,1,4,1
    base_upd = n_upd;
    scan(segv(3, 0), segv(1, 0), segv(4, 0), segv(1, 0));
    check("scan1_valid", 32'(bus.valid_o), 32'h0);
    scan(segv(3, 0), segv(1, 0), segv(4, 0), segv(1, 0));
    check("scan2_bcd",   32'(bus.bcd_o),   32'h3141);
    check("scan2_valid", 32'(bus.valid_o), 32'hF);
    check("scan2_pulses", 32'(n_upd - base_upd), 32'd4);

    // glitch rejection on digit 0
    base_upd = n_upd;
    scan(segv(3, 0), segv(1, 0), segv(4, 0), segv(8, 0));
    scan(segv(3, 0), segv(1, 0), segv(4, 0), segv(1, 0));
    scan(segv(3, 0), segv(1, 0), segv(4, 0), segv(1, 0));
    check("glitch_d0", 32'(bus.bcd_o[3:0]), 32'h1);
    check("glitch_pulses", 32'(n_upd - base_upd), 32'd0);

    // illegal pattern on digit 2
    s_bad = {7'b1010101, 1'b1};
    base_upd = n_upd;
    scan(segv(3, 0), s_bad, segv(4, 0), segv(1, 0));
    scan(segv(3, 0), s_bad, segv(4, 0), segv(1, 0));
    check("illegal_err", 32'(bus.err_o), 32'h1);
    check("illegal_d2", 32'(bus.bcd_o[11:8]), 32'hE);
    check("illegal_pulses", 32'(n_upd - base_upd), 32'd1);
    scan(segv(3, 0), segv(1, 0), segv(4, 0), segv(1, 0));
    scan(segv(3, 0), segv(1, 0), segv(4, 0), segv(1, 0));
    check("err_sticky", 32'(bus.err_o), 32'h1);
    check("restore_bcd", 32'(bus.bcd_o), 32'h3141);

    // blanking and multiple-zero anodes
    base_upd = n_upd;
    dwell(4'hF, segv(8, 1), 100, 0, 0);
    dwell(4'b0011, segv(8, 1), 20, 0, 0);
    check("blank_pulses", 32'(n_upd - base_upd), 32'd0);

    // commit lands 5 edges into the dwell
    dwell(4'b1101, segv(9, 0), 16, 0, 0);
    dwell(4'b1110, segv(1, 0), 16, 0, 0);
    last_upd_c = -1;
    dwell(4'b1101, segv(9, 0), 16, 0, 0);
    check("commit_cycle", 32'(last_upd_c), 32'd5);

    // CE low for 3 cycles mid-settle delays the sample by 3
    dwell(4'b0111, segv(7, 1), 16, 0, 0);
    dwell(4'b1011, segv(1, 0), 16, 0, 0);
    last_upd_c = -1;
    dwell(4'b0111, segv(7, 1), 16, 2, 3);
    check("ce_gap_cycle", 32'(last_upd_c), 32'd8);

    // anode toggling faster than the settle time
    base_upd = n_upd;
    for (int n = 0; n < 10; n++) begin
      dwell(4'b1110, segv(2, 0), 3, 0, 0);
      dwell(4'b1101, segv(2, 0), 3, 0, 0);
    end
    check("toggle_pulses", 32'(n_upd - base_upd), 32'd0);

    // randomized dwells against the model
    for (int k = 0; k < DIGITS; k++) begin
      tgt[k] = 4'($urandom_range(0, 9)); tgt_dp[k] = 1'($urandom_range(0, 1));
    end
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      d = 0;
      if (r == 0) an = 4'hF;
      else if (r == 1) an = 4'b0101;
      else begin
        do begin
          d  = $urandom_range(0, DIGITS - 1);
          an = ~(4'b0001 << d);
        end while (an == prev_an);
      end
      if ($urandom_range(0, 4) == 0) tgt[d] = 4'($urandom_range(0, 9));
      r = $urandom_range(0, 9);
      if (r == 0) p = 7'h7F;
      else if (r == 1) p = 7'($urandom);
      else p = PAT[tgt[d]];
      dwell(an, {p, ~tgt_dp[d]}, $urandom_range(3, 20), $urandom_range(1, 6), $urandom_range(0, 3));
    end

    // reset asserted on a committing sample edge
    bus.an_i = 4'hF; bus.ce_i = 1'b1;
    rst = 1'b1; @(posedge clk); #1; model_reset(); check_outputs(1'b0);
    rst = 1'b0; prev_an = 4'hF;
    dwell(4'b1110, segv(5, 1), 16, 0, 0);
    dwell(4'b1101, segv(5, 0), 16, 0, 0);
    bus.an_i = 4'b1110; bus.seg_i = segv(5, 1); bus.ce_i = 1'b1;
    for (int c = 0; c < SETTLE + 1; c++) begin @(posedge clk); #1; check_outputs(1'b0); end
    rst = 1'b1; @(posedge clk); #1; model_reset(); check_outputs(1'b0);
    check("midrst_bcd",   32'(bus.bcd_o),    32'h0000FFFF);
    check("midrst_valid", 32'(bus.valid_o),  32'h0);
    check("midrst_upd",   32'(bus.update_o), 32'h0);
    rst = 1'b0; bus.an_i = 4'hF; prev_an = 4'hF;
    dwell(4'hF, segv(5, 1), 4, 0, 0);
    dwell(4'b1110, segv(5, 1), 16, 0, 0);
    dwell(4'b1101, segv(5, 0), 16, 0, 0);
    dwell(4'b1110, segv(5, 1), 16, 0, 0);
    check("recover_d0", 32'(bus.bcd_o[3:0]), 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
